// File: rtl/prng_pkg.sv
// prng_pkg: shared constants, FSM encoding and seed sanitising for prng_req_arbiter
package prng_pkg;
    localparam int LFSR_W = 13;
    localparam int CASR_W = 11;
    localparam int SEED_W = LFSR_W + CASR_W;
    localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 13'h0924;
    localparam logic [CASR_W-1:0] DEF_CASR_SEED = 11'h0AA;

    typedef enum logic [2:0] {IDLE, STEP, CAPT, GRANT, SEED} state_t;

    // An all-zero half would lock its register up, so each half is replaced independently
    function automatic logic [SEED_W-1:0] sanitize(input logic [SEED_W-1:0] s);
        return {(s[SEED_W-1:CASR_W] == '0) ? DEF_LFSR_SEED : s[SEED_W-1:CASR_W],
                (s[CASR_W-1:0] == '0) ? DEF_CASR_SEED : s[CASR_W-1:0]};
    endfunction
endpackage

// File: rtl/prng_req_arbiter_if.sv
// prng_req_arbiter_if: requester, reseed and generator-core signals of the shared PRNG
interface prng_req_arbiter_if
    import prng_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W = 8
);
    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   gnt_o;
    logic [W-1:0]      rnd_o;
    logic              rnd_valid_o;
    logic              seed_load_i;
    logic [SEED_W-1:0] seed_i;
    logic              busy_o;
    logic              gen_step_o;
    logic              gen_load_o;
    logic [SEED_W-1:0] gen_seed_o;
    logic [W-1:0]      gen_number_i;

    modport slave (
        input  req_i, seed_load_i, seed_i, gen_number_i,
        output gnt_o, rnd_o, rnd_valid_o, busy_o, gen_step_o, gen_load_o, gen_seed_o
    );
    modport master (
        output req_i, seed_load_i, seed_i, gen_number_i,
        input  gnt_o, rnd_o, rnd_valid_o, busy_o, gen_step_o, gen_load_o, gen_seed_o
    );
endinterface

// File: rtl/prng_rr_pick.sv
// prng_rr_pick: combinational round-robin pick of the first request at or above ptr, wrapping
module prng_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_win,
    output logic            o_any
);
    // Lowest set bit overall is the wrap-around fallback; lowest set bit >= ptr overrides it
    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_win = PW'(i);
                o_any = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i] && i >= int'(i_ptr)) o_win = PW'(i);
        end
    end
endmodule

// File: rtl/prng_req_arbiter.sv
// prng_req_arbiter: shares one steppable PRNG core between NREQ requesters round-robin,
// and sequences lock-up-safe reseeding of the core between transactions.
module prng_req_arbiter
    import prng_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W = 8
) (
    input logic clk,
    input logic reset,
    prng_req_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state, w_next;
    logic [PW-1:0]     r_ptr, r_win, w_pick, w_ptr_nxt;
    logic              w_any;
    logic              r_seed_pending;
    logic [SEED_W-1:0] r_seed_reg, w_seed_nxt, r_gen_seed;
    logic [NREQ-1:0]   r_gnt, w_gnt;
    logic [W-1:0]      r_rnd;
    logic              r_rnd_valid, r_step, r_load;

    prng_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req(bus.req_i),
        .i_ptr(r_ptr),
        .o_win(w_pick),
        .o_any(w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // A pending reseed is serviced straight out of GRANT so it costs only one extra cycle
    always_comb begin
        w_next = (r_state == IDLE) ? (r_seed_pending ? SEED : (w_any ? STEP : IDLE)) :
                 (r_state == STEP) ? CAPT :
                 (r_state == CAPT) ? GRANT :
                 (r_state == GRANT && r_seed_pending) ? SEED : IDLE;
    end

    // A seed arriving in the very cycle SEED is entered is the newest value, so it is used directly
    always_comb begin
        w_gnt = (w_next == GRANT) ? NREQ'(1) << r_win : '0;
        w_seed_nxt = sanitize(bus.seed_load_i ? bus.seed_i : r_seed_reg);
        w_ptr_nxt = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt          <= '0;
            r_rnd          <= '0;
            r_rnd_valid    <= 1'b0;
            r_step         <= 1'b0;
            r_load         <= 1'b0;
            r_gen_seed     <= '0;
            r_ptr          <= '0;
            r_win          <= '0;
            r_seed_pending <= 1'b0;
            r_seed_reg     <= '0;
        end else begin
            r_gnt       <= w_gnt;
            r_rnd_valid <= w_next == GRANT;
            r_step      <= w_next == STEP;
            r_load      <= w_next == SEED;
            if (r_state == CAPT) r_rnd <= bus.gen_number_i;
            if (w_next == SEED) r_gen_seed <= w_seed_nxt;
            if (r_state == IDLE && w_next == STEP) r_win <= w_pick;
            if (r_state == GRANT) r_ptr <= w_ptr_nxt;
            if (bus.seed_load_i) begin
                r_seed_reg     <= bus.seed_i;
                r_seed_pending <= 1'b1;
            end else if (r_state == SEED) r_seed_pending <= 1'b0;
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.rnd_o       = r_rnd;
    assign bus.rnd_valid_o = r_rnd_valid;
    assign bus.gen_step_o  = r_step;
    assign bus.gen_load_o  = r_load;
    assign bus.gen_seed_o  = r_gen_seed;
    assign bus.busy_o      = (r_state != IDLE) || r_seed_pending;
endmodule
